// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs ADD / ADDI / BNE field requests into 32-bit RV32I instruction words,
// buffers them in a small FIFO and streams them into instruction memory at
// consecutive word addresses. Serves as the program loader ahead of CPU
// release and as a stimulus source for decoder benches.
//
// Ports
//   clk          in   1           clock, all state on rising edge
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           begin a load session (IDLE/DONE only)
//   req_valid    in   1           request present
//   req_ready    out  1           request accepted when valid && ready
//   req_op       in   2           00 ADD, 01 ADDI, 10 BNE, 11 illegal
//   req_rd       in   5           destination register (ADD/ADDI)
//   req_rs1      in   5           source register 1
//   req_rs2      in   5           source register 2 (ADD/BNE)
//   req_imm      in   12          ADDI: imm[11:0]; BNE: offset[12:1]
//   req_last     in   1           final request of the session
//   wr_ready     in   1           memory can take a write this cycle
//   wr_en        out  1           instruction memory write strobe
//   wr_addr      out  ADDR_WIDTH  byte address of the write
//   wr_data      out  DATA_WIDTH  encoded instruction (0 when not writing)
//   instr_count  out  ADDR_WIDTH  words written this session
//   done         out  1           session complete, memory image final
//   err          out  1           sticky: illegal op seen this session
//
// States
//   state   | meaning
//   S_IDLE  | after reset, waiting for start
//   S_LOAD  | accepting requests, writing buffered words
//   S_DRAIN | last request taken, flushing the FIFO to memory
//   S_DONE  | image complete, done held until the next start
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rs2,
  input  logic [11:0]           req_imm,
  input  logic                  req_last,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] instr_count,
  output logic                  done,
  output logic                  err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_BNE  = 2'b10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(4);
  localparam logic [PTR_W:0]        DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  logic [PTR_W:0]        fifo_count_q;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [DATA_WIDTH-1:0] enc_word;
  logic                  enc_legal;
  logic                  sess_start;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign fifo_full  = (fifo_count_q == DEPTH_C);
  assign fifo_empty = (fifo_count_q == '0);

  // --------------------------------------------------------------------------
  // Encoder. BNE takes offset[12:1] in req_imm, so req_imm[11] is offset[12]
  // and req_imm[10] is offset[11] in the B-type bit scatter.
  // --------------------------------------------------------------------------
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (req_op)
      OP_ADD:  enc_word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_OP};
      OP_ADDI: enc_word = {req_imm, req_rs1, 3'b000, req_rd, OPC_OP_IMM};
      OP_BNE:  enc_word = {req_imm[11], req_imm[9:4], req_rs2, req_rs1, 3'b001,
                           req_imm[3:0], req_imm[10], OPC_BRANCH};
      default: enc_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM. req_ready depends only on registered state so the request side has
  // no combinational path from wr_ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    sess_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          sess_start = 1'b1;
        end
      end
      S_LOAD: begin
        req_ready = !fifo_full;
        if (req_valid && !fifo_full && req_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done   = (state_q == S_DONE);
  assign accept = req_valid && req_ready;
  assign push   = accept && enc_legal;

  // Write side is combinational from wr_ready for single-cycle throughput.
  assign wr_en   = !fifo_empty && wr_ready;
  assign pop     = wr_en;
  assign wr_data = wr_en ? fifo_mem[rptr_q] : '0;

  // --------------------------------------------------------------------------
  // FIFO storage: data only, no reset needed since occupancy gates every read.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= enc_word;
  end

  // --------------------------------------------------------------------------
  // FIFO pointers, write address, word counter and sticky error.
  // Session start wipes everything so a stale image never carries over.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_count_q <= '0;
      wr_addr      <= BASE_C;
      instr_count  <= '0;
      err          <= 1'b0;
    end else if (sess_start) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_count_q <= '0;
      wr_addr      <= BASE_C;
      instr_count  <= '0;
      err          <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) begin
        rptr_q      <= rptr_q + PTR_W'(1);
        wr_addr     <= wr_addr + STEP_C;
        instr_count <= instr_count + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + (PTR_W + 1)'(1);
        2'b01:   fifo_count_q <= fifo_count_q - (PTR_W + 1)'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
      if (accept && !enc_legal) err <= 1'b1;
    end
  end

endmodule
